// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider.
package div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration on the {rem, quo} shift pair.
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_next,
  output logic [N-1:0] quo_next
);

  logic [N:0] trial;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    trial = {rem, quo[N-1]} - {1'b0, divisor};
    if (trial[N]) begin
      rem_next = {rem[N-2:0], quo[N-1]};
      quo_next = {quo[N-2:0], 1'b0};
    end else begin
      rem_next = trial[N-1:0];
      quo_next = {quo[N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle divider for DIV/DIVU/REM/REMU.
//
// state | meaning
// IDLE  | waiting for a start
// CALC  | one restoring step per edge, count N-1 down to 0
// FIX   | sign correction and result select (fast paths resolve here too)
// DONE  | o_valid high for one cycle; a new start may be accepted
module div_unit
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [1:0]   i_div_op,
  input  logic [N-1:0] i_op_a,
  input  logic [N-1:0] i_op_b,
  input  logic         i_flush,
  output logic         o_busy,
  output logic         o_valid,
  output logic [N-1:0] o_div_data
);

  localparam int CW = $clog2(N);

  div_state_t   state;
  logic [CW-1:0] count;
  logic [N-1:0] quo_q, rem_q, dvs_q;
  logic         neg_quo, neg_rem, sel_rem;

  logic         is_signed, a_neg, b_neg, div_zero, sgn_ovf;
  logic [N-1:0] mag_a, mag_b, quo_fix, rem_fix;
  logic [N-1:0] quo_next, rem_next;

  div_step #(.N(N)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Operand magnitudes, special-case detection and final sign fix.
  always_comb begin
    is_signed = ~i_div_op[0];
    a_neg     = is_signed & i_op_a[N-1];
    b_neg     = is_signed & i_op_b[N-1];
    mag_a     = a_neg ? -i_op_a : i_op_a;
    mag_b     = b_neg ? -i_op_b : i_op_b;
    div_zero  = (i_op_b == '0);
    sgn_ovf   = is_signed && (i_op_a == {1'b1, {(N-1){1'b0}}}) && (i_op_b == '1);
    quo_fix   = neg_quo ? -quo_q : quo_q;
    rem_fix   = neg_rem ? -rem_q : rem_q;
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      count      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
      sel_rem    <= 1'b0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_div_data <= '0;
    end else if (i_flush && state != IDLE) begin
      state   <= IDLE;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state   <= IDLE;
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
          if (i_start && !i_flush) begin
            sel_rem <= i_div_op[1];
            count   <= CW'(N - 1);
            o_busy  <= 1'b1;
            // Fast paths skip CALC; FIX then passes the preset values through.
            if (div_zero) begin
              quo_q   <= '1;
              rem_q   <= i_op_a;
              neg_quo <= 1'b0;
              neg_rem <= 1'b0;
              state   <= FIX;
            end else if (sgn_ovf) begin
              quo_q   <= {1'b1, {(N-1){1'b0}}};
              rem_q   <= '0;
              neg_quo <= 1'b0;
              neg_rem <= 1'b0;
              state   <= FIX;
            end else begin
              quo_q   <= mag_a;
              rem_q   <= '0;
              dvs_q   <= mag_b;
              neg_quo <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - 1'b1;
          end
        end
        FIX: begin
          o_div_data <= sel_rem ? rem_fix : quo_fix;
          o_busy     <= 1'b0;
          o_valid    <= 1'b1;
          state      <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors plus a few model-checked pairs.
module tb_div_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   div_op = 2'b00;
  logic [N-1:0] op_a = '0;
  logic [N-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic         busy, valid;
  logic [N-1:0] div_data;

  div_unit #(.N(N)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_div_op   (div_op),
    .i_op_a     (op_a),
    .i_op_b     (op_b),
    .i_flush    (flush),
    .o_busy     (busy),
    .o_valid    (valid),
    .o_div_data (div_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] data;
    int           at;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected result and cycle.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: got data %h at cycle %0d, expected no valid", div_data, cyc);
      end else begin
        e = sb.pop_front();
        if (div_data !== e.data || cyc != e.at) begin
          n_bad++;
          $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                   e.name, div_data, cyc, e.data, e.at);
        end
      end
    end
  end

  // Drive one start; optionally queue the expected result lat edges after acceptance.
  task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] want, input int lat, input bit push, input string name);
    exp_t x;
    @(negedge clk);
    start = 1'b1; div_op = op; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    if (push) begin
      x.data = want; x.at = cyc + lat; x.name = name;
      sb.push_back(x);
    end
    start = 1'b0; op_a = '0; op_b = '0; div_op = 2'b00;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !valid && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got %0d results pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [N-1:0] model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? N'($signed(a) % $signed(b)) : N'($signed(a) / $signed(b));
    return op[1] ? a % b : a / b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy_ok;
    logic [1:0]   rop;
    logic [N-1:0] ra, rb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_valid", {31'b0, valid}, 32'h0);
    check("reset_data", div_data, 32'h0);
    rst_n = 1'b1;

    // Unsigned divide with busy tracked across the whole computation.
    issue(2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1, "divu_100_7");
    busy_ok = 1'b1;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
    end
    check("busy_during_calc", {31'b0, busy_ok}, 32'h1);
    @(negedge clk);
    check("busy_after_done", {31'b0, busy}, 32'h0);
    wait_idle("divu_100_7");

    issue(2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b1, "remu_100_7");
    wait_idle("remu_100_7");
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1, "div_m7_2");
    wait_idle("div_m7_2");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1, "rem_m7_2");
    wait_idle("rem_m7_2");
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b1, "rem_7_m2");
    wait_idle("rem_7_m2");
    issue(2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4, 33, 1'b1, "div_m8_m2");
    wait_idle("div_m8_m2");
    issue(2'b01, 32'd3, 32'd10, 32'd0, 33, 1'b1, "divu_3_10");
    wait_idle("divu_3_10");
    issue(2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFD, 33, 1'b1, "rem_m3_5");
    wait_idle("rem_m3_5");

    // Fast paths.
    issue(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, "divu_5_0");
    wait_idle("divu_5_0");
    issue(2'b10, 32'd5, 32'd0, 32'd5, 1, 1'b1, "rem_5_0");
    wait_idle("rem_5_0");
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1, "div_ovf");
    wait_idle("div_ovf");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b1, "rem_ovf");
    wait_idle("rem_ovf");

    // Start while busy must not disturb the op in flight.
    issue(2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1, "ignore_restart");
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; div_op = 2'b11; op_a = 32'd50; op_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("ignore_restart");

    // Back-to-back: second start sampled during DONE, pulses 34 cycles apart.
    issue(2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1, "b2b_first");
    repeat (33) @(posedge clk);
    issue(2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b1, "b2b_second");
    wait_idle("b2b");

    // Flush mid-CALC: no valid, idle afterwards, then a normal op.
    issue(2'b01, 32'd1000, 32'd7, 32'd0, 33, 1'b0, "flush_victim");
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'h0);
    check("flush_keeps_data", div_data, 32'd2);
    repeat (30) @(negedge clk);
    issue(2'b01, 32'd9, 32'd3, 32'd3, 33, 1'b1, "divu_9_3_after_flush");
    wait_idle("after_flush");

    // Flush and start on the same edge: start dropped.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; div_op = 2'b01; op_a = 32'd8; op_b = 32'd2;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_dropped", {31'b0, busy}, 32'h0);
    repeat (40) @(negedge clk);

    // Reset mid-CALC.
    issue(2'b01, 32'd1000, 32'd7, 32'd0, 33, 1'b0, "reset_victim");
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", {31'b0, busy}, 32'h0);
    check("midreset_valid", {31'b0, valid}, 32'h0);
    check("midreset_data", div_data, 32'h0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Pseudo-random pairs against the arithmetic model.
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = (i % 3 == 0) ? ($urandom() >> $urandom_range(20, 28)) : $urandom();
      if (i % 3 == 1 && rb[31] == 1'b0) rb = rb | 32'h8000_0000;
      issue(rop, ra, rb, model(rop, ra, rb), (rb == '0) ? 1 : 33, 1'b1, "random_pair");
      wait_idle("random_pair");
    end

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
